// File: rtl/mcpu_if.sv
// Request/acknowledge bundle between mcpu and its instruction and data memories.
interface mcpu_if #(
    parameter int ADDR_W = 32
);
    // Handshake: a requester raises req with address/data already stable and
    // holds everything unchanged until the clock edge that samples ack=1; req
    // falls on that same edge. The responder's ack means nothing while req is low.
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_ack;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;
    logic              dmem_ack;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_ack,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_ack,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mcpu.sv
// Multi-cycle RV32I-subset core (FETCH/EXEC/MEM/WB) with sticky trap.
// Define MCPU_SLT_EN to add slt/slti; otherwise those encodings trap.
module mcpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32,
    parameter int          NREG     = 32
) (
    input  logic       clk,
    input  logic       n_reset,
    mcpu_if.master     bus,
    output logic       retire,
    output logic       trap,
    output logic [2:0] dbg_state_o
);
    localparam int IDXW = $clog2(NREG);

`ifdef MCPU_SLT_EN
    localparam logic SLT_EN = 1'b1;
`else
    localparam logic SLT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       npc_q, npc_d;
    logic [31:0]       wb_val_q, wb_val_d;
    logic              wb_en_q, wb_en_d;
    logic              imem_req_q, imem_req_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic              dmem_req_q, dmem_req_d;
    logic              dmem_we_q, dmem_we_d;
    logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
    logic [31:0]       dmem_wdata_q, dmem_wdata_d;
    logic              retire_q, retire_d;
    logic              trap_q, trap_d;
    logic [31:0]       regs_q [NREG];

    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] rv1, rv2, imm_i, imm_s, imm_b, opb;
    logic [31:0] alu_res, mem_addr, br_target;
    logic        is_r, is_i, is_lw, is_sw, is_br;
    logic        r_add, r_sub, r_and, r_or, r_slt, i_addi, i_slti;
    logic        alu_r, alu_i, known, use_rs2, use_rd, regs_ok;
    logic        br_taken, exc, rf_we;

    function automatic logic idx_legal(input logic [4:0] idx);
        return {1'b0, idx} < 6'(NREG);
    endfunction

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign f3     = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign f7     = ir_q[31:25];

    // Out-of-range indices read as zero; such instructions trap before any use.
    assign rv1 = (rs1 == 5'd0 || !idx_legal(rs1)) ? 32'd0 : regs_q[rs1[IDXW-1:0]];
    assign rv2 = (rs2 == 5'd0 || !idx_legal(rs2)) ? 32'd0 : regs_q[rs2[IDXW-1:0]];

    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};

    assign is_r  = (opcode == 7'b0110011);
    assign is_i  = (opcode == 7'b0010011);
    assign is_lw = (opcode == 7'b0000011) && (f3 == 3'b010);
    assign is_sw = (opcode == 7'b0100011) && (f3 == 3'b010);
    assign is_br = (opcode == 7'b1100011) && (f3 == 3'b000 || f3 == 3'b001);

    assign r_add  = is_r && (f7 == 7'b0000000) && (f3 == 3'b000);
    assign r_sub  = is_r && (f7 == 7'b0100000) && (f3 == 3'b000);
    assign r_and  = is_r && (f7 == 7'b0000000) && (f3 == 3'b111);
    assign r_or   = is_r && (f7 == 7'b0000000) && (f3 == 3'b110);
    assign r_slt  = SLT_EN && is_r && (f7 == 7'b0000000) && (f3 == 3'b010);
    assign i_addi = is_i && (f3 == 3'b000);
    assign i_slti = SLT_EN && is_i && (f3 == 3'b010);

    assign alu_r   = r_add | r_sub | r_and | r_or | r_slt;
    assign alu_i   = i_addi | i_slti;
    assign known   = alu_r | alu_i | is_lw | is_sw | is_br;
    assign use_rs2 = alu_r | is_sw | is_br;
    assign use_rd  = alu_r | alu_i | is_lw;
    assign regs_ok = idx_legal(rs1) && (!use_rs2 || idx_legal(rs2)) && (!use_rd || idx_legal(rd));

    assign opb     = alu_r ? rv2 : imm_i;
    assign alu_res = r_sub            ? rv1 - opb :
                     r_and            ? rv1 & opb :
                     r_or             ? rv1 | opb :
                     (r_slt | i_slti) ? {31'd0, $signed(rv1) < $signed(opb)} :
                                        rv1 + opb;

    assign mem_addr  = rv1 + (is_sw ? imm_s : imm_i);
    assign br_taken  = is_br && ((rv1 == rv2) ^ f3[0]);
    assign br_target = pc_q + imm_b;

    assign exc = !known || !regs_ok
               || ((is_lw || is_sw) && mem_addr[1:0] != 2'b00)
               || (br_taken && br_target[1]);

    assign rf_we = (state_q == S_WB) && wb_en_q && (rd != 5'd0);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        npc_d        = npc_q;
        wb_val_d     = wb_val_q;
        wb_en_d      = wb_en_q;
        imem_req_d   = imem_req_q;
        imem_addr_d  = imem_addr_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        retire_d     = 1'b0;
        trap_d       = trap_q;
        case (state_q)
            S_IDLE: begin
                state_d     = S_FETCH;
                imem_req_d  = 1'b1;
                imem_addr_d = pc_q[ADDR_W-1:0];
            end
            S_FETCH: begin
                if (bus.imem_ack) begin
                    ir_d       = bus.imem_rdata;
                    imem_req_d = 1'b0;
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exc) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                end else if (is_lw || is_sw) begin
                    state_d      = S_MEM;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = is_sw;
                    dmem_addr_d  = mem_addr[ADDR_W-1:0];
                    dmem_wdata_d = rv2;
                    wb_en_d      = is_lw;
                    npc_d        = pc_q + 32'd4;
                end else begin
                    state_d  = S_WB;
                    retire_d = 1'b1;
                    wb_en_d  = use_rd;
                    wb_val_d = alu_res;
                    npc_d    = br_taken ? br_target : pc_q + 32'd4;
                end
            end
            S_MEM: begin
                if (bus.dmem_ack) begin
                    dmem_req_d = 1'b0;
                    wb_val_d   = bus.dmem_rdata;
                    retire_d   = 1'b1;
                    state_d    = S_WB;
                end
            end
            S_WB: begin
                pc_d        = npc_q;
                state_d     = S_FETCH;
                imem_req_d  = 1'b1;
                imem_addr_d = npc_q[ADDR_W-1:0];
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            ir_q         <= '0;
            npc_q        <= '0;
            wb_val_q     <= '0;
            wb_en_q      <= 1'b0;
            imem_req_q   <= 1'b0;
            imem_addr_q  <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            retire_q     <= 1'b0;
            trap_q       <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            npc_q        <= npc_d;
            wb_val_q     <= wb_val_d;
            wb_en_q      <= wb_en_d;
            imem_req_q   <= imem_req_d;
            imem_addr_q  <= imem_addr_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            retire_q     <= retire_d;
            trap_q       <= trap_d;
            if (rf_we) regs_q[rd[IDXW-1:0]] <= wb_val_q;
        end
    end

    assign bus.imem_req   = imem_req_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.dmem_req   = dmem_req_q;
    assign bus.dmem_we    = dmem_we_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_wdata = dmem_wdata_q;
    assign retire         = retire_q;
    assign trap           = trap_q;
    assign dbg_state_o    = state_q;
endmodule

// File: doc/mcpu.md
# mcpu

Multi-cycle RV32I-subset CPU core with request/acknowledge instruction and data memory ports; the parametrised successor of the single-cycle `cpu`. It executes one instruction through a FETCH/EXEC/MEM/WB state machine and tolerates variable memory wait states. It clears its register file on reset, supports an RV32E-style reduced register count, and raises a sticky trap on illegal or misaligned operations. It sits between the top level and the instruction and data memory models.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `ADDR_W`, default 32: width of `imem_addr` and `dmem_addr`; the low `ADDR_W` bits of 32-bit addresses are driven.
- `NREG`, default 32: register count, 16 or 32.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `n_reset` in 1: asynchronous, active-low reset.
- `imem_req` out 1: instruction fetch request.
- `imem_addr` out ADDR_W: fetch address (PC).
- `imem_rdata` in 32: fetched instruction, valid with `imem_ack`.
- `imem_ack` in 1: fetch complete.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: 1 = store, 0 = load; qualified by `dmem_req`.
- `dmem_addr` out ADDR_W: data address, rs1 + imm.
- `dmem_wdata` out 32: store data (rs2).
- `dmem_rdata` in 32: load data, valid with `dmem_ack`.
- `dmem_ack` in 1: data access complete.
- `retire` out 1: one-cycle pulse when an instruction completes.
- `trap` out 1: sticky; the core has halted.

## Operation
- Supported instructions:
  - `add`, `sub`, `and`, `or`: opcode 0110011; funct3 000/000/111/110; funct7 0000000 (0100000 for sub).
  - `addi`: 0010011, funct3 000.
  - `lw`: 0000011, funct3 010.
  - `sw`: 0100011, funct3 010.
  - `beq`/`bne`: 1100011, funct3 000/001.
- Any other encoding is illegal.
- States and transitions:
  - IDLE → FETCH on the first clock edge after reset.
  - FETCH → EXEC on an edge with `imem_ack`=1; the instruction is latched.
  - EXEC → MEM for `lw`/`sw`; EXEC → WB otherwise; EXEC → TRAP on an illegal instruction.
  - MEM → WB on an edge with `dmem_ack`=1.
  - WB → FETCH.
  - TRAP is terminal until reset.
- Arithmetic: 32-bit modulo 2^32. I/S immediates are 12-bit sign-extended. The B immediate is 13-bit sign-extended with bit 0 = 0. Branch target = PC + imm.
- WB updates:
  - rd is written for ALU, `addi` and `lw`.
  - PC ← target if the branch is taken, else PC+4.
  - `retire` = 1.
- Register 0 reads 0; writes to x0 are discarded.
- With `NREG`=16, any rs1/rs2/rd index ≥ 16 is illegal.
- Trap conditions, each checked in EXEC:
  - illegal instruction;
  - `lw`/`sw` address with bits [1:0] ≠ 0;
  - taken branch target with bit 1 = 1.
- On a trap: no memory request, no register write, PC unchanged, `retire` stays 0.
- `imem_ack`/`dmem_ack` are ignored while the matching request is low.

## Timing
- Reset (asynchronous, immediate):
  - PC = `RESET_PC`; all registers = 0; state = IDLE.
  - Every output = 0, including `imem_addr`, `dmem_addr` and `dmem_wdata`.
- Outputs are registered.
- `imem_req` rises on the edge entering FETCH, with `imem_addr` = PC.
  - It stays high, with address stable, until the edge sampling `imem_ack`=1.
  - It falls on that same edge.
- `dmem_req`/`dmem_we`/`dmem_addr`/`dmem_wdata` are set on the edge entering MEM and held stable until the ack edge. `dmem_req` falls on the ack edge.
- Zero-wait latency (ack high in the first request cycle):
  - ALU/branch: 3 cycles (FETCH, EXEC, WB).
  - `lw`/`sw`: 4 cycles.
  - Each wait cycle adds 1.
- `retire` is high for exactly the WB cycle. The next `imem_req` rises on the edge leaving WB.
- Reset asserted mid-access drops the request immediately. The access is abandoned and no register or PC update occurs.

## Configuration
- `MCPU_SLT_EN` defined: adds `slt` (0110011, funct3 010, funct7 0) and `slti` (0010011, funct3 010). Both compute a signed compare and write 1 or 0, with the same latency as `add`.
- `MCPU_SLT_EN` undefined: those encodings are illegal and trap.

## Test plan
- Reset, then release, with `imem_ack` tied high:
  - first fetch has `imem_addr`=`RESET_PC`;
  - every register reads 0;
  - all outputs were 0 during reset.
- Load then add:
  - `lw x1,0(x0)` with `dmem_rdata`=32'h00FF, then `add x1,x1,x1`, then `sw x1,0(x0)`;
  - required: the store drives `dmem_we`=1, `dmem_addr`=0, `dmem_wdata`=32'h01FE;
  - the PC sequence is 0, 4, 8.
- Branches:
  - `beq x0,x0,+12` at PC 0x0C → next fetch at 0x18;
  - `bne x1,x1,+12` at 0x18 → next fetch at 0x1C.
- Wait states: `imem_ack` delayed 3 cycles and `dmem_ack` delayed 2 cycles on `lw`:
  - requests and addresses stay stable throughout;
  - `lw` retire spacing is 4+3+2 = 9 cycles.
- Traps:
  - `lw x1,2(x0)` → `trap`=1, no `dmem_req`, no `retire`;
  - with `NREG`=16, `add x20,x0,x0` → `trap`=1.
- Reset mid-access: assert `n_reset`=0 during a held `dmem_req`:
  - `dmem_req` falls immediately and the PC returns to `RESET_PC`;
  - with `MCPU_SLT_EN`, `slti x1,x0,-1` writes 0 to x1; without it, the same instruction traps.
